// File: rtl/rv_isa_pkg.sv
// RV32I opcode constants, loader op classes and FSM states.
// Opcodes are shared with the control decoder.
package rv_isa_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   localparam logic [2:0] CLS_LW  = 3'd0;
   localparam logic [2:0] CLS_SW  = 3'd1;
   localparam logic [2:0] CLS_ALU = 3'd2;
   localparam logic [2:0] CLS_ALI = 3'd3;
   localparam logic [2:0] CLS_BEQ = 3'd4;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_e;

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic fields to one RV32I word.
// Unknown classes yield a NOP and raise illegal_o.
module instr_encode
   import rv_isa_pkg::*;
(
   input  logic [2:0]  op_class_i,
   input  logic [2:0]  funct3_i,
   input  logic        funct7b5_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [12:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   // Branch offsets are halfword aligned, so bit 0 carries nothing.
   logic unused_imm;
   assign unused_imm = imm_i[0];

   always_comb begin
      word_o    = NOP_WORD;
      illegal_o = 1'b0;
      unique case (op_class_i)
         CLS_LW: begin
            word_o = {imm_i[11:0], rs1_i, F3_WORD,
                      rd_i, OP_LOAD};
         end
         CLS_SW: begin
            word_o = {imm_i[11:5], rs2_i, rs1_i,
                      F3_WORD, imm_i[4:0], OP_STORE};
         end
         CLS_ALU: begin
            word_o = {1'b0, funct7b5_i, 5'b00000,
                      rs2_i, rs1_i, funct3_i,
                      rd_i, OP_RTYPE};
         end
         CLS_ALI: begin
            word_o = {imm_i[11:0], rs1_i, funct3_i,
                      rd_i, OP_ITYPE};
         end
         CLS_BEQ: begin
            word_o = {imm_i[12], imm_i[10:5], rs2_i,
                      rs1_i, F3_BEQ, imm_i[4:1],
                      imm_i[11], OP_BRANCH};
         end
         default: begin
            word_o    = NOP_WORD;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams encoded RV32I words into instruction memory,
// one registered write per accepted handshake.
module instr_mem_loader
   import rv_isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 1024,
   parameter int          CNT_W     = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [2:0]       op_class,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [12:0]      imm,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic [CNT_W:0]   count,
   output logic             err_illegal,
   output logic             err_overflow
);

   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);
   localparam logic [CNT_W:0] ONE_C   = (CNT_W+1)'(1);

   state_e         state_q, state_d;
   logic [CNT_W:0] count_q, count_d;
   logic           we_q, we_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic           ill_q, ill_d;
   logic           ovf_q, ovf_d;

   logic [31:0]    enc_word;
   logic           enc_ill;
   logic           accept;
   logic [CNT_W:0] count_inc;

   instr_encode u_enc (
      .op_class_i (op_class),
      .funct3_i   (funct3),
      .funct7b5_i (funct7b5),
      .rd_i       (rd),
      .rs1_i      (rs1),
      .rs2_i      (rs2),
      .imm_i      (imm),
      .word_o     (enc_word),
      .illegal_o  (enc_ill)
   );

   assign in_ready  = (state_q == LOAD) && (count_q < DEPTH_C);
   assign accept    = in_valid && in_ready;
   assign count_inc = count_q + ONE_C;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ill_d   = ill_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LOAD;
               count_d = '0;
               ill_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + (32'(count_q) << 2);
               wdata_d = enc_word;
               count_d = count_inc;
               if (enc_ill) begin
                  ill_d = 1'b1;
               end
               // A last word that exactly fills memory is no overflow.
               if (in_last) begin
                  state_d = DONE;
               end else if (count_inc == DEPTH_C) begin
                  ovf_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         ill_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ill_q   <= ill_d;
         ovf_q   <= ovf_d;
      end
   end

   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign count        = count_q;
   assign busy         = (state_q == LOAD);
   assign done         = (state_q == DONE);
   assign err_illegal  = ill_q;
   assign err_overflow = ovf_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader with a field-level
// reference model (arithmetic encoding, session bookkeeping).
module tb_instr_mem_loader;

   localparam int          DEP  = 4;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready, in_last;
   logic [2:0]  op_class, funct3;
   logic        funct7b5;
   logic [4:0]  rd, rs1, rs2;
   logic [12:0] imm;
   logic        mem_we, busy, done, err_illegal, err_overflow;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  count;

   int n_vec, n_err;
   int m_st;
   int m_cnt;
   int m_wr;
   int n_wr;
   bit m_ill, m_ovf;
   logic [31:0] m_addr, m_wdata;

   instr_mem_loader #(
      .BASE_ADDR (BASE),
      .DEPTH     (DEP),
      .CNT_W     (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_last      (in_last),
      .op_class     (op_class),
      .funct3       (funct3),
      .funct7b5     (funct7b5),
      .rd           (rd),
      .rs1          (rs1),
      .rs2          (rs2),
      .imm          (imm),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done),
      .count        (count),
      .err_illegal  (err_illegal),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst === 1'b1 && mem_we === 1'b1) n_wr++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit hit, want finish");
      $fatal(1);
   end

   function automatic logic [31:0] ref_word(
      input logic [2:0] c, input logic [2:0] f3, input logic f7,
      input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [12:0] im);
      int unsigned i, r1, r2, rv, fv;
      i  = 32'(im);
      r1 = 32'(s1) << 15;
      r2 = 32'(s2) << 20;
      rv = 32'(d) << 7;
      fv = 32'(f3) << 12;
      case (c)
         3'd0: return ((i & 32'hFFF) << 20) | r1 | (32'd2 << 12)
                      | rv | 32'h03;
         3'd1: return (((i >> 5) & 32'h7F) << 25) | r2 | r1
                      | (32'd2 << 12) | ((i & 32'h1F) << 7) | 32'h23;
         3'd2: return (32'(f7) << 30) | r2 | r1 | fv | rv | 32'h33;
         3'd3: return ((i & 32'hFFF) << 20) | r1 | fv | rv | 32'h13;
         3'd4: return (((i >> 12) & 1) << 31)
                      | (((i >> 5) & 32'h3F) << 25) | r2 | r1
                      | (((i >> 1) & 32'hF) << 8)
                      | (((i >> 11) & 1) << 7) | 32'h63;
         default: return 32'h0000_0013;
      endcase
   endfunction

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_ill = 0; m_ovf = 0;
      m_addr = BASE; m_wdata = '0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (m_st != 1) begin
         m_st = 1; m_cnt = 0; m_ill = 0; m_ovf = 0;
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk); #1;
   endtask

   // One cycle with in_valid high; the model decides acceptance.
   task automatic push(
      input logic [2:0] c, input logic [2:0] f3, input logic f7,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [12:0] im, input logic last,
      output logic rdy, output logic erdy);
      op_class = c; funct3 = f3; funct7b5 = f7;
      rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_last = last; in_valid = 1'b1;
      erdy = (m_st == 1) && (m_cnt < DEP);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (erdy) begin
         m_addr  = BASE + 32'(m_cnt) * 4;
         m_wdata = ref_word(c, f3, f7, d, s1, s2, im);
         m_cnt++;
         m_wr++;
         if (c > 3'd4) m_ill = 1;
         if (last) m_st = 2;
         else if (m_cnt == DEP) begin
            m_ovf = 1; m_st = 2;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      n_vec++;
      if (mem_we !== 1'b0 || mem_addr !== BASE || mem_wdata !== 32'h0
          || count !== 3'd0 || busy !== 1'b0 || done !== 1'b0
          || in_ready !== 1'b0 || err_illegal !== 1'b0
          || err_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: we=%b addr=%h data=%h cnt=%0d busy=%b done=%b rdy=%b ei=%b eo=%b, want all zero",
                  mem_we, mem_addr, mem_wdata, count, busy, done,
                  in_ready, err_illegal, err_overflow);
      end
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: busy=%b rdy=%b we=%b, want 0 0 0",
                  busy, in_ready, mem_we);
      end
   endtask

   task automatic test_encodings();
      logic r, e;
      do_start();
      n_vec++;
      if (busy !== 1'b1 || count !== 3'd0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL enc_start: busy=%b cnt=%0d rdy=%b, want 1 0 1",
                  busy, count, in_ready);
      end
      push(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, r, e);
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0
          || mem_wdata !== 32'h002081B3 || count !== 3'd1) begin
         n_err++;
         $display("FAIL enc_ralu: we=%b addr=%h data=%h cnt=%0d, want 1 0 002081b3 1",
                  mem_we, mem_addr, mem_wdata, count);
      end
      push(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1, r, e);
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h4
          || mem_wdata !== 32'h00812283 || count !== 3'd2
          || done !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL enc_lw: we=%b addr=%h data=%h cnt=%0d done=%b busy=%b, want 1 4 00812283 2 1 0",
                  mem_we, mem_addr, mem_wdata, count, done, busy);
      end
      idle();
      n_vec++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h4
          || mem_wdata !== 32'h00812283 || count !== 3'd2) begin
         n_err++;
         $display("FAIL enc_hold: we=%b addr=%h data=%h cnt=%0d, want 0 4 00812283 2",
                  mem_we, mem_addr, mem_wdata, count);
      end
   endtask

   task automatic test_back_to_back();
      logic r, e;
      int n0;
      logic [31:0] want [3];
      want[0] = 32'h00512623;
      want[1] = 32'hFE208CE3;
      want[2] = 32'h00500093;
      n0 = n_wr;
      do_start();
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: push(3'd1, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5,
                    13'd12, 1'b0, r, e);
            1: push(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2,
                    -13'sd8, 1'b0, r, e);
            default: push(3'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0,
                          13'd5, 1'b1, r, e);
         endcase
         n_vec++;
         if (r !== 1'b1 || mem_we !== 1'b1
             || mem_addr !== 32'(k * 4) || mem_wdata !== want[k]
             || mem_wdata !== m_wdata) begin
            n_err++;
            $display("FAIL b2b_word%0d: rdy=%b we=%b addr=%h data=%h, want 1 1 %h %h",
                     k, r, mem_we, mem_addr, mem_wdata, k * 4, want[k]);
         end
      end
      idle();
      n_vec++;
      if (n_wr - n0 !== 3 || done !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_count: writes=%0d done=%b, want 3 1",
                  n_wr - n0, done);
      end
   endtask

   task automatic test_illegal();
      logic r, e;
      do_start();
      push(3'd3, 3'd7, 1'b0, 5'd9, 5'd4, 5'd0, 13'h7FF, 1'b0, r, e);
      push(3'd6, 3'd1, 1'b1, 5'd7, 5'd8, 5'd9, 13'h123, 1'b0, r, e);
      n_vec++;
      if (mem_we !== 1'b1 || mem_wdata !== 32'h00000013
          || mem_addr !== 32'h4 || err_illegal !== 1'b1) begin
         n_err++;
         $display("FAIL ill_nop: we=%b addr=%h data=%h ei=%b, want 1 4 00000013 1",
                  mem_we, mem_addr, mem_wdata, err_illegal);
      end
      push(3'd2, 3'd5, 1'b1, 5'd10, 5'd11, 5'd12, 13'd0, 1'b1, r, e);
      n_vec++;
      if (mem_wdata !== m_wdata || mem_addr !== 32'h8
          || count !== 3'd3 || err_illegal !== 1'b1 || done !== 1'b1) begin
         n_err++;
         $display("FAIL ill_next: addr=%h data=%h cnt=%0d ei=%b done=%b, want 8 %h 3 1 1",
                  mem_addr, mem_wdata, count, err_illegal, done, m_wdata);
      end
      idle();
      do_start();
      n_vec++;
      if (err_illegal !== 1'b0 || count !== 3'd0) begin
         n_err++;
         $display("FAIL ill_clear: ei=%b cnt=%0d, want 0 0",
                  err_illegal, count);
      end
      push(3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 13'd4, 1'b1, r, e);
      idle();
   endtask

   task automatic test_overflow();
      logic r, e;
      int n0;
      n0 = n_wr;
      do_start();
      for (int k = 0; k < 5; k++) begin
         push(3'(k % 4), 3'(k), 1'b0, 5'(k + 1), 5'(k + 2), 5'(k + 3),
              13'(k * 4), 1'b0, r, e);
         n_vec++;
         if (r !== e || mem_we !== e || count !== 3'(m_cnt)
             || mem_addr !== m_addr || mem_wdata !== m_wdata
             || err_overflow !== m_ovf || done !== (m_st == 2)) begin
            n_err++;
            $display("FAIL ovf_push%0d: rdy=%b we=%b cnt=%0d addr=%h data=%h eo=%b done=%b, want %b %b %0d %h %h %b %b",
                     k, r, mem_we, count, mem_addr, mem_wdata,
                     err_overflow, done, e, e, m_cnt, m_addr, m_wdata,
                     m_ovf, m_st == 2);
         end
      end
      idle();
      n_vec++;
      if (n_wr - n0 !== 4 || err_overflow !== 1'b1 || done !== 1'b1
          || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_final: writes=%0d eo=%b done=%b rdy=%b, want 4 1 1 0",
                  n_wr - n0, err_overflow, done, in_ready);
      end
   endtask

   task automatic test_reset_restart();
      logic r, e;
      do_start();
      push(3'd2, 3'd4, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, r, e);
      push(3'd3, 3'd6, 1'b0, 5'd4, 5'd5, 5'd0, 13'd99, 1'b0, r, e);
      idle();
      rst = 1'b0;
      #1;
      n_vec++;
      if (mem_we !== 1'b0 || mem_addr !== BASE || mem_wdata !== 32'h0
          || count !== 3'd0 || busy !== 1'b0 || done !== 1'b0
          || in_ready !== 1'b0 || err_illegal !== 1'b0
          || err_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: we=%b addr=%h data=%h cnt=%0d busy=%b done=%b rdy=%b, want all zero",
                  mem_we, mem_addr, mem_wdata, count, busy, done, in_ready);
      end
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      do_start();
      push(3'd1, 3'd0, 1'b0, 5'd0, 5'd6, 5'd7, 13'd40, 1'b1, r, e);
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== BASE || count !== 3'd1
          || mem_wdata !== m_wdata) begin
         n_err++;
         $display("FAIL rst_restart: we=%b addr=%h cnt=%0d data=%h, want 1 %h 1 %h",
                  mem_we, mem_addr, count, mem_wdata, BASE, m_wdata);
      end
      idle();
   endtask

   task automatic test_gating();
      logic r, e;
      int n0;
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      n0 = n_wr;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin
            do_start();
            push(3'd3, 3'd0, 1'b0, 5'd2, 5'd2, 5'd0, 13'd1, 1'b1, r, e);
            n0 = n0 + 1;
         end
         push(3'(k % 5), 3'd0, 1'b0, 5'(k), 5'(k), 5'(k), 13'(k),
              1'b0, r, e);
         n_vec++;
         if (r !== 1'b0 || e !== 1'b0 || mem_we !== 1'b0
             || n_wr !== n0) begin
            n_err++;
            $display("FAIL gate%0d: rdy=%b we=%b writes=%0d, want 0 0 %0d",
                     k, r, mem_we, n_wr, n0);
         end
      end
      idle();
   endtask

   task automatic test_random();
      logic r, e;
      logic [2:0] c;
      int n0;
      for (int s = 0; s < 25; s++) begin
         n0 = n_wr - m_wr;
         do_start();
         for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               idle();
               n_vec++;
               if (mem_we !== 1'b0 || mem_addr !== m_addr
                   || mem_wdata !== m_wdata) begin
                  n_err++;
                  $display("FAIL rnd_gap s%0d: we=%b addr=%h data=%h, want 0 %h %h",
                           s, mem_we, mem_addr, mem_wdata, m_addr, m_wdata);
               end
            end
            c = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                            : 3'($urandom_range(0, 4));
            push(c, 3'($urandom), 1'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), 13'($urandom),
                 ($urandom_range(0, 3) == 0), r, e);
            n_vec++;
            if (r !== e || mem_we !== e || count !== 3'(m_cnt)
                || mem_addr !== m_addr || mem_wdata !== m_wdata
                || err_illegal !== m_ill || err_overflow !== m_ovf
                || done !== (m_st == 2) || busy !== (m_st == 1)) begin
               n_err++;
               $display("FAIL rnd s%0d k%0d: rdy=%b we=%b cnt=%0d addr=%h data=%h ei=%b eo=%b done=%b, want %b %b %0d %h %h %b %b %b",
                        s, k, r, mem_we, count, mem_addr, mem_wdata,
                        err_illegal, err_overflow, done, e, e, m_cnt,
                        m_addr, m_wdata, m_ill, m_ovf, m_st == 2);
            end
         end
         idle();
         n_vec++;
         if (n_wr - m_wr !== n0) begin
            n_err++;
            $display("FAIL rnd_writes s%0d: seen=%0d, want %0d",
                     s, n_wr - n0, m_wr);
         end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; m_wr = 0; n_wr = 0;
      model_reset();
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      op_class = '0; funct3 = '0; funct7b5 = 1'b0;
      rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      test_reset();
      test_encodings();
      test_back_to_back();
      test_illegal();
      test_overflow();
      test_reset_restart();
      m_wr = n_wr;
      test_gating();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
